sram_access_ctrl: RTL
=====================

Name: sram_access_ctrl

Overview:
- Single-port access controller between the 8-bit core's execute stage and the 64x8 data SRAM.
- Serialises core load/store and push/pop requests into SRAM cycles and owns the hardware stack pointer.
- Drives SRAM write-enable, address and write data; captures the SRAM's combinational read data.
- Every state change is gated by the system clock-enable clk_valid.

Parameters:
- ADDR_W, 6, SRAM address width
- DATA_W, 8, data width
- STACK_TOP, 63, highest stack address; first push lands here
- STACK_LIMIT, 48, lowest stack address; stack depth = STACK_TOP-STACK_LIMIT+1 = 16

Ports:
- clk  in  1  system clock
- arst_n  in  1  reset (see Behaviour)
- clk_valid  in  1  clock enable; no state changes while low
- req  in  1  core request, sampled only in IDLE
- op  in  2  00 LD, 01 ST, 10 PUSH, 11 POP
- addr  in  ADDR_W  LD/ST address; ignored for PUSH/POP
- wdata  in  DATA_W  ST/PUSH data
- ack  out  1  one-cycle completion pulse
- resp_err  out  1  valid with ack; operation rejected
- rdata  out  DATA_W  LD/POP result, held until next LD/POP completes
- busy  out  1  high in ACCESS and RESP
- sp  out  ADDR_W  next free stack slot = STACK_TOP - cnt
- err_ovf  out  1  sticky push-overflow flag
- err_unf  out  1  sticky pop-underflow flag
- err_clr  in  1  clears sticky flags
- sram_write_en  out  1  to SRAM
- sram_addr  out  ADDR_W  to SRAM
- sram_data_out  out  DATA_W  write data to SRAM
- sram_data_in  in  DATA_W  combinational read data from SRAM

Behaviour:
- Reset: arst_n is asynchronous, active-low; clock is clk. On reset: state IDLE, cnt=0 (sp=63), ack=0, resp_err=0, rdata=0, err_ovf=0, err_unf=0, sram_write_en=0, sram_addr=0, sram_data_out=0.
- Reset mid-operation aborts the operation with no ack. A write never half-completes, because sram_write_en drops asynchronously with the state.
- Every register update is qualified by clk_valid. With clk_valid low, the FSM, counters, flags and ack hold their values.
- IDLE:
  - On req & clk_valid: latch op, addr, wdata and the error decision, then go to ACCESS.
  - PUSH address = STACK_TOP-cnt. POP address = STACK_TOP-cnt+1.
  - Error decision: PUSH with cnt==DEPTH is an overflow; POP with cnt==0 is an underflow.
- ACCESS:
  - sram_addr and sram_data_out are driven from the latched registers.
  - sram_write_en = (ST or PUSH) & !err, combinational from state.
  - LD/POP without error: rdata <= sram_data_in.
  - PUSH ok: cnt+1. POP ok: cnt-1. Errored PUSH/POP leave cnt unchanged.
  - Next state RESP.
- RESP: ack=1 and resp_err=err for exactly one clk_valid cycle, then IDLE.
- Latency: request accepted at edge N produces ack high during cycle N+2, counting clk_valid cycles only. Throughput is one op per 3 cycles. req is ignored while busy.
- An errored op sets err_ovf or err_unf in ACCESS. Both flags stay high until err_clr & clk_valid. If set and clear occur in the same cycle, set wins.
- LD/ST may address any location, including the stack region.
- An errored POP leaves rdata unchanged.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Defined: LD/ST with STACK_LIMIT <= addr <= STACK_TOP is rejected. ST performs no write; LD leaves rdata unchanged; resp_err=1 with ack. Sticky flags are not affected.
- Undefined: no address check; LD/ST to the stack region behave normally.

Decomposition:
- Shared package uc_mem_pkg holds:
  - op encodings OP_LD, OP_ST, OP_PUSH, OP_POP
  - FSM state encodings IDLE/ACCESS/RESP
  - STACK_TOP/STACK_LIMIT defaults
- One natural sub-module, stack_ptr_unit: holds cnt, computes push/pop addresses, full/empty and sp; updates on inc/dec strobes qualified by clk_valid.
- FSM and SRAM drive stay in the top module.

Test Plan:
- Reset then ST addr=5 wdata=A5, LD addr=5 -> write pulse on cycle N+1 with sram_addr=5; LD ack at N+2 with rdata=A5, resp_err=0.
- PUSH 11,22,33 then POP x3 -> writes go to 63,62,61; sp ends at 60 after the pushes; POPs return 33,22,11; sp back to 63.
- 16 PUSHes then a 17th -> 17th gives no write, resp_err=1, err_ovf=1, sp=47. Then err_clr pulse -> err_ovf=0.
- POP on empty stack -> resp_err=1, err_unf=1, rdata unchanged, sp=63. err_clr and a new underflow in the same cycle -> err_unf stays 1.
- clk_valid held low for 3 cycles during ACCESS of a ST -> no SRAM write and no ack until clk_valid returns; ack follows exactly one enabled cycle after the write.
- arst_n asserted during ACCESS of a PUSH -> sram_write_en=0 immediately, no ack, sp=63 after release. With STACK_GUARD_EN defined, LD addr=50 -> resp_err=1 with rdata unchanged.

Source files
------------

// File: rtl/uc_mem_pkg.sv
// Shared encodings and stack defaults for the core-to-SRAM access path.
package uc_mem_pkg;

  typedef enum logic [1:0] {
    OP_LD   = 2'b00,
    OP_ST   = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam int DEF_STACK_TOP   = 63;
  localparam int DEF_STACK_LIMIT = 48;

  function automatic logic op_writes(input op_e o);
    return (o == OP_ST) || (o == OP_PUSH);
  endfunction

endpackage

// File: rtl/stack_ptr_unit.sv
// Hardware stack occupancy counter; stack grows downward from STACK_TOP.
module stack_ptr_unit
  import uc_mem_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int STACK_TOP   = DEF_STACK_TOP,
  parameter int STACK_LIMIT = DEF_STACK_LIMIT
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clk_valid,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] pop_addr,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = STACK_TOP - STACK_LIMIT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_reg <= '0;
    end else if (clk_valid) begin
      if (inc && !full) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else if (dec && !empty) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  assign sp       = ADDR_W'(STACK_TOP) - ADDR_W'(cnt_reg);
  assign pop_addr = sp + ADDR_W'(1);
  assign full     = (cnt_reg == CNT_W'(DEPTH));
  assign empty    = (cnt_reg == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Serialises core LD/ST/PUSH/POP into single-port SRAM cycles (IDLE->ACCESS->RESP).
// Define STACK_GUARD_EN to reject LD/ST that target the stack region.
module sram_access_ctrl
  import uc_mem_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int STACK_TOP   = DEF_STACK_TOP,
  parameter int STACK_LIMIT = DEF_STACK_LIMIT
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clk_valid,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              resp_err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sp,
  output logic              err_ovf,
  output logic              err_unf,
  input  logic              err_clr,
  output logic              sram_write_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_out,
  input  logic [DATA_W-1:0] sram_data_in
);

  state_e            state_reg;
  op_e               op_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              ack_reg;
  logic              resp_err_reg;
  logic              ovf_reg;
  logic              unf_reg;

  op_e               op_in;
  logic              in_access;
  logic              sp_inc;
  logic              sp_dec;
  logic [ADDR_W-1:0] pop_addr;
  logic              full;
  logic              empty;
  logic              guard_hit;
  logic [ADDR_W-1:0] req_addr;
  logic              req_err;

  assign op_in     = op_e'(op);
  assign in_access = (state_reg == ACCESS);
  assign sp_inc    = in_access && (op_reg == OP_PUSH) && !err_reg;
  assign sp_dec    = in_access && (op_reg == OP_POP) && !err_reg;

  stack_ptr_unit #(
    .ADDR_W     (ADDR_W),
    .STACK_TOP  (STACK_TOP),
    .STACK_LIMIT(STACK_LIMIT)
  ) u_stack_ptr (
    .clk      (clk),
    .arst_n   (arst_n),
    .clk_valid(clk_valid),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp),
    .pop_addr (pop_addr),
    .full     (full),
    .empty    (empty)
  );

`ifdef STACK_GUARD_EN
  // Widened compare keeps the upper bound meaningful when STACK_TOP is the last address.
  assign guard_hit = ({1'b0, addr} >= (ADDR_W+1)'(STACK_LIMIT)) &&
                     ({1'b0, addr} <= (ADDR_W+1)'(STACK_TOP));
`else
  assign guard_hit = 1'b0;
`endif

  always_comb begin
    req_addr = addr;
    req_err  = guard_hit;
    case (op_in)
      OP_PUSH: begin
        req_addr = sp;
        req_err  = full;
      end
      OP_POP: begin
        req_addr = pop_addr;
        req_err  = empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg    <= IDLE;
      op_reg       <= OP_LD;
      err_reg      <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      ack_reg      <= 1'b0;
      resp_err_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
    end else if (clk_valid) begin
      if (err_clr) begin
        ovf_reg <= 1'b0;
        unf_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (req) begin
            op_reg    <= op_in;
            addr_reg  <= req_addr;
            wdata_reg <= wdata;
            err_reg   <= req_err;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (!err_reg && !op_writes(op_reg)) begin
            rdata_reg <= sram_data_in;
          end
          // Placed after the clear so a coincident set takes priority.
          if (err_reg && (op_reg == OP_PUSH)) ovf_reg <= 1'b1;
          if (err_reg && (op_reg == OP_POP))  unf_reg <= 1'b1;
          ack_reg      <= 1'b1;
          resp_err_reg <= err_reg;
          state_reg    <= RESP;
        end
        RESP: begin
          ack_reg      <= 1'b0;
          resp_err_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Combinational from state so an asynchronous reset kills the strobe at once.
  assign sram_write_en = in_access && op_writes(op_reg) && !err_reg;
  assign sram_addr     = addr_reg;
  assign sram_data_out = wdata_reg;

  assign ack      = ack_reg;
  assign resp_err = resp_err_reg;
  assign rdata    = rdata_reg;
  assign busy     = (state_reg != IDLE);
  assign err_ovf  = ovf_reg;
  assign err_unf  = unf_reg;

endmodule
